// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the single 8-bit data-memory port.
// Master 0 is the CPU load/store path, master 1 the peripheral/DMA master.
// Registered grants, round-robin tie break, bounded hold under contention,
// shared bus mux and registered read-valid strobes back to the owner.
module data_bus_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_Req0,
  input  logic [ADDR_W-1:0] i_Addr0,
  input  logic [DATA_W-1:0] i_Dout0,
  input  logic              i_RW0,
  input  logic              i_Req1,
  input  logic [ADDR_W-1:0] i_Addr1,
  input  logic [DATA_W-1:0] i_Dout1,
  input  logic              i_RW1,
  input  logic [DATA_W-1:0] i_Din,
  output logic              o_Gnt0,
  output logic              o_Gnt1,
  output logic [ADDR_W-1:0] o_Addr,
  output logic [DATA_W-1:0] o_Dout,
  output logic              o_RW,
  output logic [DATA_W-1:0] o_RdData,
  output logic              o_RdValid0,
  output logic              o_RdValid1
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state;
  logic              last;      // most recent owner: 0 = master 0, 1 = master 1
  logic [HOLD_W-1:0] hold_cnt;

  logic xfer0;
  logic xfer1;

  // A transfer happens only when the owner is actually requesting.
  assign xfer0 = o_Gnt0 & i_Req0;
  assign xfer1 = o_Gnt1 & i_Req1;

  // Arbitration FSM with registered grants and read-valid strobes.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      o_Gnt0     <= 1'b0;
      o_Gnt1     <= 1'b0;
      o_RdValid0 <= 1'b0;
      o_RdValid1 <= 1'b0;
      hold_cnt   <= '0;
      last       <= 1'b1;
    end else begin
      o_RdValid0 <= xfer0 & ~i_RW0;
      o_RdValid1 <= xfer1 & ~i_RW1;
      case (state)
        IDLE: begin
          if (i_Req0 && (!i_Req1 || last)) begin
            state    <= OWN0;
            o_Gnt0   <= 1'b1;
            o_Gnt1   <= 1'b0;
            last     <= 1'b0;
            hold_cnt <= '0;
          end else if (i_Req1) begin
            state    <= OWN1;
            o_Gnt0   <= 1'b0;
            o_Gnt1   <= 1'b1;
            last     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        OWN0: begin
          if (!i_Req0) begin
            hold_cnt <= '0;
            if (i_Req1) begin
              state  <= OWN1;
              o_Gnt0 <= 1'b0;
              o_Gnt1 <= 1'b1;
              last   <= 1'b1;
            end else begin
              state  <= IDLE;
              o_Gnt0 <= 1'b0;
              o_Gnt1 <= 1'b0;
            end
          end else if (!i_Req1) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LIMIT) begin
            state    <= OWN1;
            o_Gnt0   <= 1'b0;
            o_Gnt1   <= 1'b1;
            last     <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        OWN1: begin
          if (!i_Req1) begin
            hold_cnt <= '0;
            if (i_Req0) begin
              state  <= OWN0;
              o_Gnt0 <= 1'b1;
              o_Gnt1 <= 1'b0;
              last   <= 1'b0;
            end else begin
              state  <= IDLE;
              o_Gnt0 <= 1'b0;
              o_Gnt1 <= 1'b0;
            end
          end else if (!i_Req0) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LIMIT) begin
            state    <= OWN0;
            o_Gnt0   <= 1'b1;
            o_Gnt1   <= 1'b0;
            last     <= 1'b0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          o_Gnt0   <= 1'b0;
          o_Gnt1   <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

  // Shared bus mux; idle and no-op cycles present a harmless read of address 0.
  always_comb begin
    o_Addr = '0;
    o_Dout = '0;
    o_RW   = 1'b0;
    if (xfer0) begin
      o_Addr = i_Addr0;
      o_Dout = i_Dout0;
      o_RW   = i_RW0;
    end else if (xfer1) begin
      o_Addr = i_Addr1;
      o_Dout = i_Dout1;
      o_RW   = i_RW1;
    end
  end

  assign o_RdData = i_Din;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: a spec-level reference model pushes expected
// per-cycle outputs into a scoreboard when inputs are driven; a negedge
// monitor pops and compares. Directed scenarios add fixed-value checks.
module tb_data_bus_arbiter;

  localparam int MAX_HOLD = 4;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       req0, rw0, req1, rw1;
  logic [7:0] addr0, dout0, addr1, dout1, din;
  logic       gnt0, gnt1, rw, rv0, rv1;
  logic [7:0] addr, dout, rddata;

  int n_vec = 0;
  int n_err = 0;

  data_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_HOLD(MAX_HOLD)) dut (
    .Clk(Clk), .Rst(Rst),
    .i_Req0(req0), .i_Addr0(addr0), .i_Dout0(dout0), .i_RW0(rw0),
    .i_Req1(req1), .i_Addr1(addr1), .i_Dout1(dout1), .i_RW1(rw1),
    .i_Din(din),
    .o_Gnt0(gnt0), .o_Gnt1(gnt1), .o_Addr(addr), .o_Dout(dout), .o_RW(rw),
    .o_RdData(rddata), .o_RdValid0(rv0), .o_RdValid1(rv1)
  );

  always #5 Clk = ~Clk;

  // Memory model: read data for the presented address appears one cycle later.
  always @(posedge Clk) din <= addr ^ 8'hB5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic       g0, g1, rw, v0, v1;
    logic [7:0] addr, dout, rd;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic       m_known = 1'b0;
  int         m_own   = 0;   // 0 idle, 1 master 0, 2 master 1
  int         m_hold  = 0;
  logic       m_last  = 1'b1;
  logic       m_v0 = 1'b0, m_v1 = 1'b0;
  logic [7:0] m_rd = 8'h00;

  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("gnt0", gnt0, e.g0);
      check("gnt1", gnt1, e.g1);
      check("addr", addr, e.addr);
      check("dout", dout, e.dout);
      check("rw", rw, e.rw);
      check("rdvalid0", rv0, e.v0);
      check("rdvalid1", rv1, e.v1);
      if (e.v0 || e.v1) check("rddata", rddata, e.rd);
    end
  end

  // Drive one cycle of inputs just after the edge, predict this cycle's
  // outputs, then advance the model to the state after the next edge.
  task automatic cyc(input logic rst, input logic r0, input logic [7:0] a0, input logic [7:0] d0,
                     input logic w0, input logic r1, input logic [7:0] a1, input logic [7:0] d1,
                     input logic w1);
    exp_t e;
    logic x0, x1, mine, other;
    int   nxt;
    @(posedge Clk);
    #1;
    Rst = rst; req0 = r0; addr0 = a0; dout0 = d0; rw0 = w0;
    req1 = r1; addr1 = a1; dout1 = d1; rw1 = w1;
    x0 = (m_own == 1) && r0;
    x1 = (m_own == 2) && r1;
    if (m_known) begin
      e.g0   = (m_own == 1);
      e.g1   = (m_own == 2);
      e.addr = x0 ? a0 : (x1 ? a1 : 8'h00);
      e.dout = x0 ? d0 : (x1 ? d1 : 8'h00);
      e.rw   = x0 ? w0 : (x1 ? w1 : 1'b0);
      e.v0   = m_v0;
      e.v1   = m_v1;
      e.rd   = m_rd;
      sb.push_back(e);
    end
    if (rst) begin
      m_known = 1'b1; m_own = 0; m_last = 1'b1; m_hold = 0; m_v0 = 1'b0; m_v1 = 1'b0;
    end else begin
      m_v0 = x0 && !w0;
      m_v1 = x1 && !w1;
      if (x0) m_rd = a0 ^ 8'hB5;
      if (x1) m_rd = a1 ^ 8'hB5;
      nxt = m_own;
      if (m_own == 0) begin
        if (r0 && (!r1 || m_last)) nxt = 1;
        else if (r1) nxt = 2;
      end else begin
        mine  = (m_own == 1) ? r0 : r1;
        other = (m_own == 1) ? r1 : r0;
        if (!mine) nxt = other ? 3 - m_own : 0;
        else if (!other) m_hold = 0;
        else if (m_hold == MAX_HOLD - 1) nxt = 3 - m_own;
        else m_hold++;
      end
      if (nxt != m_own) begin
        m_hold = 0;
        if (nxt != 0) m_last = (nxt == 2);
      end
      m_own = nxt;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  int exp_seq[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    Rst = 1'b1; req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
    addr0 = '0; dout0 = '0; addr1 = '0; dout1 = '0;

    // Reset with both requesting, then release: master 0 wins first tie
    cyc(1'b1, 1'b1, 8'h01, 8'h11, 1'b1, 1'b1, 8'h02, 8'h22, 1'b1);
    cyc(1'b1, 1'b1, 8'h01, 8'h11, 1'b1, 1'b1, 8'h02, 8'h22, 1'b1);
    @(negedge Clk);
    check("t1_rst_gnt", {gnt0, gnt1}, 2'b00);
    check("t1_rst_addr", addr, 8'h00);
    check("t1_rst_rw", rw, 1'b0);
    cyc(1'b0, 1'b1, 8'h01, 8'h11, 1'b1, 1'b1, 8'h02, 8'h22, 1'b1);
    cyc(1'b0, 1'b1, 8'h01, 8'h11, 1'b1, 1'b1, 8'h02, 8'h22, 1'b1);
    @(negedge Clk);
    check("t1_first_gnt0", {gnt0, gnt1}, 2'b10);
    idle(2);

    // Lone master 1 write
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h20, 8'h5A, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h20, 8'h5A, 1'b1);
    @(negedge Clk);
    check("t2_gnt1", {gnt0, gnt1}, 2'b01);
    check("t2_bus", {addr, dout, rw}, {8'h20, 8'h5A, 1'b1});
    idle(1);
    @(negedge Clk);
    check("t2_no_rdvalid", {rv0, rv1}, 2'b00);

    // Continuous contention: MAX_HOLD cycles each, no idle bubble
    cyc(1'b0, 1'b1, 8'h40, 8'hC0, 1'b1, 1'b1, 8'h41, 8'hC1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b1, 8'h40, 8'hC0, 1'b1, 1'b1, 8'h41, 8'hC1, 1'b1);
      @(negedge Clk);
      check("t3_seq", gnt1 ? 1 : (gnt0 ? 0 : 2), exp_seq[i]);
    end
    idle(2);

    // Master 0 read of 0x10 returns 0xA5 one cycle after the transfer
    cyc(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(1);
    @(negedge Clk);
    check("t4_rdvalid", {rv0, rv1}, 2'b10);
    check("t4_rddata", rddata, 8'hA5);
    idle(1);

    // Owner drops while other waits, then both drop
    cyc(1'b0, 1'b1, 8'h50, 8'h05, 1'b1, 1'b1, 8'h60, 8'h06, 1'b1);
    cyc(1'b0, 1'b1, 8'h50, 8'h05, 1'b1, 1'b1, 8'h60, 8'h06, 1'b1);
    cyc(1'b0, 1'b1, 8'h50, 8'h05, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge Clk);
    check("t5_handover", {gnt0, gnt1}, 2'b10);
    idle(1);
    @(negedge Clk);
    check("t5_idle", {gnt0, gnt1, addr}, {2'b00, 8'h00});

    // Reset during a master 1 read transfer
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h33, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h33, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h70, 8'h07, 1'b1, 1'b1, 8'h71, 8'h17, 1'b1);
    @(negedge Clk);
    check("t6_after_rst", {gnt0, gnt1, rv0, rv1}, 4'b0000);
    cyc(1'b0, 1'b1, 8'h70, 8'h07, 1'b1, 1'b1, 8'h71, 8'h17, 1'b1);
    @(negedge Clk);
    check("t6_gnt0_first", {gnt0, gnt1}, 2'b10);

    // Random traffic checked against the model
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
          1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
    end
    idle(2);
    @(negedge Clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
